// File: rtl/led_pattern_sequencer.sv
// Prescaled LED pattern sequencer: rotate-left/right, bounce and fill patterns with run/pause and single-step.
// leds update one cycle after the advancing tick/step; inputs are sampled every cycle, no backpressure.
module led_pattern_sequencer #(
  parameter int N_LEDS   = 4,
  parameter int TICK_DIV = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic [1:0]        mode_sel,
  input  logic              mode_load,
  input  logic [1:0]        speed,
  output logic [N_LEDS-1:0] leds,
  output logic              tick,
  output logic              running
);

  typedef enum logic [1:0] {
    MODE_ROTL   = 2'd0,
    MODE_ROTR   = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [N_LEDS-1:0] LED1 = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] ONES = '1;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic                dir_up_q, dir_up_d;
  logic [N_LEDS-1:0]   leds_q, leds_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         period_m1;
  logic                wrap;
  logic                adv;
  logic                is_onehot;
  logic                is_thermo;

  // >= rather than == so a speed change that shrinks the period wraps at once
  assign period_m1 = (32'(TICK_DIV) >> speed) - 32'd1;
  assign wrap      = 32'(cnt_q) >= period_m1;
  assign tick      = wrap & ~mode_load & ~rst;
  assign cnt_d     = (wrap | mode_load) ? '0 : cnt_q + CNT_W'(1);

  assign is_onehot = (leds_q != '0) && ((leds_q & (leds_q - LED1)) == '0);
  assign is_thermo = (leds_q & (leds_q + LED1)) == '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PAUSE: if (run)  state_d = ST_RUN;
      ST_RUN:   if (!run) state_d = ST_PAUSE;
      default:  state_d = ST_PAUSE;
    endcase
  end

  assign adv = (state_q == ST_RUN) ? tick : step;

  always_comb begin
    mode_d   = mode_q;
    leds_d   = leds_q;
    dir_up_d = dir_up_q;
    if (mode_load) begin
      mode_d   = mode_e'(mode_sel);
      leds_d   = LED1;
      dir_up_d = 1'b1;
    end else if (adv) begin
      case (mode_q)
        MODE_ROTL: begin
          if (!is_onehot) begin
            leds_d   = LED1;
            dir_up_d = 1'b1;
          end else begin
            leds_d = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
          end
        end
        MODE_ROTR: begin
          if (!is_onehot) begin
            leds_d   = LED1;
            dir_up_d = 1'b1;
          end else begin
            leds_d = {leds_q[0], leds_q[N_LEDS-1:1]};
          end
        end
        MODE_BOUNCE: begin
          if (!is_onehot) begin
            leds_d   = LED1;
            dir_up_d = 1'b1;
          end else if ((dir_up_q && !leds_q[N_LEDS-1]) || leds_q[0]) begin
            leds_d   = leds_q << 1;
            dir_up_d = !leds_d[N_LEDS-1];
          end else begin
            leds_d   = leds_q >> 1;
            dir_up_d = leds_d[0];
          end
        end
        default: begin
          if (!is_thermo) begin
            leds_d   = LED1;
            dir_up_d = 1'b1;
          end else if ((dir_up_q && leds_q != ONES) || leds_q == '0) begin
            leds_d   = (leds_q << 1) | LED1;
            dir_up_d = (leds_d != ONES);
          end else begin
            leds_d   = leds_q >> 1;
            dir_up_d = (leds_d == '0);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_PAUSE;
      mode_q   <= MODE_ROTL;
      dir_up_q <= 1'b1;
      leds_q   <= LED1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      dir_up_q <= dir_up_d;
      leds_q   <= leds_d;
      cnt_q    <= cnt_d;
    end
  end

  assign leds    = leds_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed literal sequences plus randomized stimulus against a phase-based model.
module tb_led_pattern_sequencer;
  localparam int N  = 4;
  localparam int TD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       mode_load = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [N-1:0] leds;
  logic       tick;
  logic       running;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  led_pattern_sequencer #(.N_LEDS(N), .TICK_DIV(TD), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .mode_sel(mode_sel),
    .mode_load(mode_load), .speed(speed), .leds(leds), .tick(tick), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Model: prescaler count, mode, a phase index within the mode's cyclic sequence, run state.
  int   m_cnt = 0;
  int   m_mode = 0;
  int   m_ph = 0;
  logic m_run = 1'b0;
  logic armed = 1'b0;
  logic m_wrap, m_tk, m_adv;

  function automatic logic [N-1:0] mdl_leds(input int mode, input int ph);
    int pos, lvl;
    case (mode)
      0, 1: return N'(1 << ph);
      2: begin
        pos = (ph < N) ? ph : 2 * N - 2 - ph;
        return N'(1 << pos);
      end
      default: begin
        lvl = (ph <= N) ? ph : 2 * N - ph;
        return N'((1 << lvl) - 1);
      end
    endcase
  endfunction

  function automatic int next_ph(input int mode, input int ph);
    case (mode)
      0:       return (ph + 1) % N;
      1:       return (ph + N - 1) % N;
      2:       return (ph + 1) % (2 * N - 2);
      default: return (ph + 1) % (2 * N);
    endcase
  endfunction

  always_comb begin
    m_wrap = m_cnt >= (TD >> speed) - 1;
    m_tk   = m_wrap && !mode_load && !rst;
    m_adv  = m_run ? m_tk : step;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_mode <= 0;
      m_ph   <= 0;
      m_run  <= 1'b0;
      armed  <= 1'b1;
    end else begin
      if (mode_load) begin
        m_mode <= int'(mode_sel);
        m_ph   <= (mode_sel == 2'd3) ? 1 : 0;
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_wrap ? 0 : m_cnt + 1;
        if (m_adv) m_ph <= next_ph(m_mode, m_ph);
      end
      m_run <= run;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_leds", 32'(leds), 32'(mdl_leds(m_mode, m_ph)));
      chk("model_tick", 32'(tick), 32'(m_tk));
      chk("model_running", 32'(running), 32'(m_run));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic wait_tick(output int at);
    at = -1;
    for (int i = 0; i < 64; i++) begin
      if (tick) begin
        at = cyc_n;
        break;
      end
      cyc();
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_tick: no tick within 64 cycles (cycle %0d)", cyc_n);
    end
  endtask

  task automatic load(input logic [1:0] sel);
    mode_sel  = sel;
    mode_load = 1'b1;
    cyc();
    mode_load = 1'b0;
  endtask

  // Advance through one tick and check the resulting pattern.
  task automatic tick_expect(input string nm, input logic [N-1:0] exp);
    int t;
    wait_tick(t);
    cyc();
    chk(nm, 32'(leds), 32'(exp));
  endtask

  logic [N-1:0] bounce_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic [N-1:0] fill_seq   [4] = '{4'b0011, 4'b0111, 4'b1111, 4'b0111};

  initial begin
    int t0, t1, ld_cyc;
    repeat (3) cyc();
    chk("rst_leds", 32'(leds), 32'h1);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);

    // ROTL at 1x: tick every 8 cycles, one rotation per tick
    rst = 1'b0;
    run = 1'b1;
    wait_tick(t0);
    cyc();
    chk("rotl_1", 32'(leds), 32'h2);
    chk("rotl_running", 32'(running), 32'h1);
    wait_tick(t1);
    chk("tick_period", 32'(t1 - t0), 32'd8);
    cyc();
    chk("rotl_2", 32'(leds), 32'h4);
    tick_expect("rotl_3", 4'b1000);
    tick_expect("rotl_4", 4'b0001);

    // BOUNCE never repeats an endpoint
    load(2'd2);
    chk("bounce_seed", 32'(leds), 32'h1);
    foreach (bounce_seq[i]) tick_expect("bounce_seq", bounce_seq[i]);

    // FILL single-stepped while paused
    run = 1'b0;
    load(2'd3);
    chk("fill_seed", 32'(leds), 32'h1);
    chk("pause_running", 32'(running), 32'h0);
    foreach (fill_seq[i]) begin
      step = 1'b1;
      cyc();
      step = 1'b0;
      chk("fill_step", 32'(leds), 32'(fill_seq[i]));
      chk("fill_running", 32'(running), 32'h0);
      cyc();
      cyc();
    end
    wait_tick(t0);
    cyc();
    chk("pause_no_adv", 32'(leds), 32'h7);

    // speed change shrinking the period below the count wraps at once
    run = 1'b1;
    load(2'd0);
    repeat (6) cyc();
    chk("pre_speed_tick", 32'(tick), 32'h0);
    speed = 2'd3;
    #1;
    chk("speed_wrap", 32'(tick), 32'h1);
    cyc();
    chk("fast_tick_a", 32'(tick), 32'h1);
    chk("fast_leds_a", 32'(leds), 32'h2);
    cyc();
    chk("fast_tick_b", 32'(tick), 32'h1);
    chk("fast_leds_b", 32'(leds), 32'h4);
    speed = 2'd0;

    // mode_load coinciding with tick: tick suppressed, no advance, prescaler restarts
    wait_tick(t0);
    mode_sel  = 2'd0;
    mode_load = 1'b1;
    #1;
    chk("load_tick_suppr", 32'(tick), 32'h0);
    ld_cyc = cyc_n;
    cyc();
    mode_load = 1'b0;
    chk("load_leds", 32'(leds), 32'h1);
    wait_tick(t1);
    chk("load_next_tick", 32'(t1 - ld_cyc), 32'd8);
    cyc();
    chk("load_adv", 32'(leds), 32'h2);

    // reset mid-BOUNCE while descending
    load(2'd2);
    tick_expect("mid_b1", 4'b0010);
    tick_expect("mid_b2", 4'b0100);
    tick_expect("mid_b3", 4'b1000);
    tick_expect("mid_b4", 4'b0100);
    rst = 1'b1;
    run = 1'b0;
    #1;
    chk("rst_tick_low", 32'(tick), 32'h0);
    cyc();
    rst = 1'b0;
    chk("mid_rst_leds", 32'(leds), 32'h1);
    chk("mid_rst_running", 32'(running), 32'h0);
    run = 1'b1;
    tick_expect("post_rst_1", 4'b0010);
    tick_expect("post_rst_2", 4'b0100);
    tick_expect("post_rst_3", 4'b1000);
    tick_expect("post_rst_rotl", 4'b0001);

    // ROTR
    load(2'd1);
    tick_expect("rotr_1", 4'b1000);
    tick_expect("rotr_2", 4'b0100);

    for (int i = 0; i < 3000; i++) begin
      step      = ($urandom_range(0, 7) == 0);
      mode_load = ($urandom_range(0, 31) == 0);
      mode_sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) run = ~run;
      if ($urandom_range(0, 63) == 0) speed = 2'($urandom_range(0, 3));
      rst       = ($urandom_range(0, 499) == 0);
      cyc();
    end
    step = 1'b0;
    mode_load = 1'b0;
    rst = 1'b0;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
